// File: rtl/cam_line_packer.sv
// Packs RGB565 pixels into the UDP line FIFO, appends a two-word trailer per
// line and tracks frame/line geometry, drops and geometry errors.
module cam_line_packer #(
  parameter int H_PIX   = 640,
  parameter int V_LINES = 480,
  parameter bit VS_POL  = 1'b1
) (
  input  logic        i_pclk,
  input  logic        rst_n,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [15:0] i_pix,
  input  logic        i_pix_vld,
  input  logic        i_fifo_full,
  output logic        o_wr_en,
  output logic [15:0] o_wr_data,
  output logic        o_line_done,
  output logic [11:0] o_line_num,
  output logic [7:0]  o_frame_num,
  output logic        o_line_err,
  output logic        o_frame_err,
  output logic        o_overflow
);

  typedef enum logic [2:0] {IDLE, WAIT_LINE, LINE, TRL0, TRL1} state_t;

  localparam logic [11:0] HPixC   = 12'(H_PIX);
  localparam logic [11:0] VLinesC = 12'(V_LINES);

  state_t      state_q, state_d;
  logic        vs_q, de_q;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]  frame_num_q, frame_num_d;
  logic        err_acc_q, err_acc_d;
  logic        line_drop_q, line_drop_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        line_done_q, line_done_d;
  logic [11:0] line_num_q, line_num_d;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q, overflow_d;

  logic        frame_start, de_rise, want_wr, trl_err;
  logic [15:0] want_data;

  assign frame_start = (i_vsync == VS_POL) && (vs_q != VS_POL);
  assign de_rise     = i_de & ~de_q;

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    frame_num_d = frame_num_q;
    err_acc_d   = err_acc_q;
    line_drop_d = line_drop_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    line_done_d = 1'b0;
    line_num_d  = line_num_q;
    line_err_d  = line_err_q;
    frame_err_d = frame_err_q;
    overflow_d  = overflow_q;
    want_wr     = 1'b0;
    want_data   = '0;
    trl_err     = 1'b0;

    // Frame start overrides everything; an interrupted line is charged to the new frame.
    if (frame_start) begin
      frame_num_d = frame_num_q + 8'd1;
      line_cnt_d  = '0;
      frame_err_d = err_acc_q;
      err_acc_d   = (state_q == LINE) || (state_q == TRL0) || (state_q == TRL1);
      state_d     = WAIT_LINE;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_LINE: begin
          if (de_rise) begin
            if (line_cnt_q >= VLinesC) begin
              err_acc_d = 1'b1;
            end else begin
              state_d     = LINE;
              pix_cnt_d   = '0;
              line_drop_d = 1'b0;
              if (i_pix_vld) begin
                want_wr   = 1'b1;
                want_data = i_pix;
                pix_cnt_d = 12'd1;
              end
            end
          end
        end
        LINE: begin
          if (!i_de) begin
            state_d = TRL0;
          end else if (i_pix_vld) begin
            want_wr   = 1'b1;
            want_data = i_pix;
            if (pix_cnt_q != 12'hFFF) pix_cnt_d = pix_cnt_q + 12'd1;
          end
        end
        TRL0: begin
          want_wr   = 1'b1;
          want_data = {4'hE, line_cnt_q};
          state_d   = TRL1;
          if (de_rise) err_acc_d = 1'b1;
        end
        TRL1: begin
          want_wr     = 1'b1;
          want_data   = {frame_num_q[3:0], pix_cnt_q};
          trl_err     = (pix_cnt_q != HPixC) | line_drop_q | i_fifo_full;
          line_done_d = 1'b1;
          line_num_d  = line_cnt_q;
          line_err_d  = trl_err;
          line_cnt_d  = line_cnt_q + 12'd1;
          state_d     = WAIT_LINE;
          if (trl_err || de_rise) err_acc_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (want_wr) begin
      if (i_fifo_full) begin
        line_drop_d = 1'b1;
        overflow_d  = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = want_data;
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      line_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      frame_num_q <= 8'hFF;
      err_acc_q   <= 1'b0;
      line_drop_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      line_done_q <= 1'b0;
      line_num_q  <= '0;
      line_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= i_vsync;
      de_q        <= i_de;
      line_cnt_q  <= line_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_num_q <= frame_num_d;
      err_acc_q   <= err_acc_d;
      line_drop_q <= line_drop_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      line_done_q <= line_done_d;
      line_num_q  <= line_num_d;
      line_err_q  <= line_err_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_wr_en     = wr_en_q;
  assign o_wr_data   = wr_data_q;
  assign o_line_done = line_done_q;
  assign o_line_num  = line_num_q;
  assign o_frame_num = frame_num_q;
  assign o_line_err  = line_err_q;
  assign o_frame_err = frame_err_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_cam_line_packer.sv
// Self-checking bench for cam_line_packer: FIFO words are predicted into a
// scoreboard queue as stimulus is driven and compared as the DUT writes them.
module tb_cam_line_packer;

  localparam int H_PIX   = 640;
  localparam int V_LINES = 2;

  logic        i_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_de = 1'b0;
  logic [15:0] i_pix = '0;
  logic        i_pix_vld = 1'b0;
  logic        i_fifo_full = 1'b0;
  logic        o_wr_en;
  logic [15:0] o_wr_data;
  logic        o_line_done;
  logic [11:0] o_line_num;
  logic [7:0]  o_frame_num;
  logic        o_line_err;
  logic        o_frame_err;
  logic        o_overflow;

  cam_line_packer #(.H_PIX(H_PIX), .V_LINES(V_LINES), .VS_POL(1'b1)) dut (
    .i_pclk(i_pclk), .rst_n(rst_n), .i_vsync(i_vsync), .i_de(i_de),
    .i_pix(i_pix), .i_pix_vld(i_pix_vld), .i_fifo_full(i_fifo_full),
    .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_line_done(o_line_done),
    .o_line_num(o_line_num), .o_frame_num(o_frame_num), .o_line_err(o_line_err),
    .o_frame_err(o_frame_err), .o_overflow(o_overflow)
  );

  always #5 i_pclk = ~i_pclk;

  logic [15:0] expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  int          wrCount = 0;
  int          doneCnt = 0;
  logic [11:0] lastNum = '0;
  logic        lastErr = 1'b0;
  logic [7:0]  tbFrame = 8'hFF;
  int          tbLine = 0;

  // Scoreboard monitor: outputs are sampled on the falling edge.
  always @(negedge i_pclk) begin
    logic [15:0] expWord;
    if (rst_n) begin
      if (o_wr_en) begin
        wrCount++;
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_write got=%h required=none", o_wr_data);
        end else begin
          expWord = expQ.pop_front();
          if (o_wr_data !== expWord) begin
            mismatched++;
            $display("[TB] FAIL wr_data got=%h required=%h", o_wr_data, expWord);
          end
        end
      end
      if (o_line_done) begin
        doneCnt++;
        lastNum = o_line_num;
        lastErr = o_line_err;
      end
    end
  end

  task automatic tick();
    @(posedge i_pclk);
    #1;
  endtask

  task automatic frameStart();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    tick();
    tbFrame = tbFrame + 8'd1;
    tbLine = 0;
  endtask

  task automatic sendLine(input int n, input int dropFrom, input int dropCnt);
    bit cap;
    cap = (tbLine < V_LINES);
    i_de = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      i_pix_vld = 1'b0;
      tick();
      i_pix = 16'($urandom);
      i_pix_vld = 1'b1;
      i_fifo_full = (i >= dropFrom) && (i < dropFrom + dropCnt);
      if (cap && !i_fifo_full) expQ.push_back(i_pix);
      tick();
    end
    i_pix_vld = 1'b0;
    i_fifo_full = 1'b0;
    i_de = 1'b0;
    if (cap) begin
      expQ.push_back({4'hE, 12'(tbLine)});
      expQ.push_back({tbFrame[3:0], 12'(n)});
      tbLine++;
    end
    repeat (4) tick();
  endtask

  task automatic checkVal(input string name, input int got, input int req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("[TB] FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checkVal("rst_wr_en", int'(o_wr_en), 0);
    checkVal("rst_wr_data", int'(o_wr_data), 0);
    checkVal("rst_line_done", int'(o_line_done), 0);
    checkVal("rst_line_num", int'(o_line_num), 0);
    checkVal("rst_frame_num", int'(o_frame_num), 'hFF);
    checkVal("rst_line_err", int'(o_line_err), 0);
    checkVal("rst_frame_err", int'(o_frame_err), 0);
    checkVal("rst_overflow", int'(o_overflow), 0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_ignore();
    int w0;
    w0 = wrCount;
    for (int k = 0; k < 3; k++) begin
      i_de = 1'b1;
      tick();
      i_pix = 16'($urandom);
      i_pix_vld = 1'b1;
      tick();
      i_de = 1'b0;
      tick();
      i_pix_vld = 1'b0;
      tick();
    end
    repeat (3) tick();
    checkVal("idle_writes", wrCount - w0, 0);
    checkVal("idle_frame_num", int'(o_frame_num), 'hFF);
  endtask

  task automatic test_full_line();
    int d0;
    frameStart();
    checkVal("first_frame_num", int'(o_frame_num), 0);
    d0 = doneCnt;
    sendLine(640, -1, 0);
    checkVal("full_done_cnt", doneCnt - d0, 1);
    checkVal("full_line_num", int'(lastNum), 0);
    checkVal("full_line_err", int'(lastErr), 0);
    checkVal("full_queue_empty", expQ.size(), 0);
  endtask

  task automatic test_short_line();
    sendLine(639, -1, 0);
    checkVal("short_line_num", int'(lastNum), 1);
    checkVal("short_line_err", int'(lastErr), 1);
    frameStart();
    checkVal("short_frame_err", int'(o_frame_err), 1);
    checkVal("short_frame_num", int'(o_frame_num), int'(tbFrame));
  endtask

  task automatic test_fifo_full();
    sendLine(640, 10, 3);
    checkVal("drop_line_err", int'(lastErr), 1);
    checkVal("drop_overflow", int'(o_overflow), 1);
    sendLine(640, -1, 0);
    checkVal("clean_line_err", int'(lastErr), 0);
    checkVal("overflow_sticky", int'(o_overflow), 1);
    frameStart();
    checkVal("drop_frame_err", int'(o_frame_err), 1);
    checkVal("drop_queue_empty", expQ.size(), 0);
  endtask

  task automatic test_midline_vsync();
    int d0;
    d0 = doneCnt;
    i_de = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      i_pix_vld = 1'b0;
      tick();
      i_pix = 16'($urandom);
      i_pix_vld = 1'b1;
      expQ.push_back(i_pix);
      tick();
    end
    i_pix_vld = 1'b0;
    frameStart();
    i_de = 1'b0;
    repeat (4) tick();
    checkVal("abort_no_done", doneCnt - d0, 0);
    checkVal("abort_frame_num", int'(o_frame_num), int'(tbFrame));
    checkVal("abort_queue_empty", expQ.size(), 0);
    sendLine(640, -1, 0);
    checkVal("after_abort_line_num", int'(lastNum), 0);
    checkVal("after_abort_line_err", int'(lastErr), 0);
    frameStart();
    checkVal("abort_frame_err", int'(o_frame_err), 1);
  endtask

  task automatic test_vlines();
    int d0, w0;
    d0 = doneCnt;
    w0 = wrCount;
    sendLine(640, -1, 0);
    sendLine(640, -1, 0);
    sendLine(640, -1, 0);
    checkVal("vlines_done_cnt", doneCnt - d0, 2);
    checkVal("vlines_writes", wrCount - w0, 2 * 642);
    checkVal("vlines_last_num", int'(lastNum), 1);
    frameStart();
    checkVal("vlines_frame_err", int'(o_frame_err), 1);
  endtask

  task automatic test_frame_wrap();
    int guard;
    guard = 0;
    while (tbFrame != 8'hFF && guard < 300) begin
      frameStart();
      guard++;
    end
    checkVal("wrap_pre_ff", int'(o_frame_num), 'hFF);
    frameStart();
    checkVal("wrap_to_zero", int'(o_frame_num), 0);
    checkVal("wrap_frame_err", int'(o_frame_err), 0);
    sendLine(640, -1, 0);
    checkVal("wrap_line_num", int'(lastNum), 0);
    checkVal("final_queue_empty", expQ.size(), 0);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_line();
    test_short_line();
    test_fifo_full();
    test_midline_vsync();
    test_vlines();
    test_frame_wrap();
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
